// File: rtl/xyz_sweep_ctrl.sv
// xyz_sweep_ctrl: sweeps {x,y,z} through all 8 vectors and captures {a,b,c} into a truth table
module xyz_sweep_ctrl #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic [2:0]  vec_idx,
  output logic        busy,
  output logic        done,
  output logic [23:0] truth_tbl
);
  localparam int CW = $clog2(HOLD_CYCLES + 1) < 1 ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  assign {x, y, z} = vec_idx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      vec_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      truth_tbl <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= DRIVE;
          busy      <= 1'b1;
          truth_tbl <= '0;
          vec_idx   <= '0;
          cnt       <= '0;
        end
        DRIVE: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            truth_tbl[3*vec_idx +: 3] <= {a, b, c};
            cnt <= '0;
            if (vec_idx == 3'd7) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              vec_idx <= '0;
            end else begin
              vec_idx <= vec_idx + 3'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_xyz_sweep_ctrl.sv
// tb_xyz_sweep_ctrl: directed checks of sweep timing and truth-table capture for H=10 and H=1
module tb_xyz_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start10 = 1'b0, start1 = 1'b0;
  logic mode = 1'b0;
  logic a10, b10, c10, x10, y10, z10, busy10, done10;
  logic x1, y1, z1, busy1, done1;
  logic [2:0] vec10, vec1;
  logic [23:0] tbl10, tbl1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // mode 0: identity stub, mode 1: a=x&y, b=y|z, c=x^z
  always_comb begin
    a10 = mode ? (x10 & y10) : x10;
    b10 = mode ? (y10 | z10) : y10;
    c10 = mode ? (x10 ^ z10) : z10;
  end

  xyz_sweep_ctrl #(.HOLD_CYCLES(10)) u10 (
    .clk(clk), .rst(rst), .start(start10), .a(a10), .b(b10), .c(c10),
    .x(x10), .y(y10), .z(z10), .vec_idx(vec10), .busy(busy10), .done(done10),
    .truth_tbl(tbl10)
  );

  xyz_sweep_ctrl #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(x1), .b(y1), .c(z1),
    .x(x1), .y(y1), .z(z1), .vec_idx(vec1), .busy(busy1), .done(done1),
    .truth_tbl(tbl1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // point k is the negedge after edge T+k, where T is the edge that accepts start
  task automatic trace10(input int pa, input int pb, input logic [23:0] exp_tbl);
    logic [2:0] v;
    start10 = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 81; k++) begin
      v = (k < 80) ? 3'(k / 10) : 3'd0;
      chk($sformatf("h10_k%0d", k), {24'd0, busy10, done10, vec10, x10, y10, z10},
          {24'd0, k < 80, k == 80, v, v});
      if (k == 0) chk("h10_tbl_clear", {8'd0, tbl10}, 32'd0);
      if (k == 80) chk("h10_tbl", {8'd0, tbl10}, {8'd0, exp_tbl});
      start10 = (k == pa) || (k == pb);
      @(negedge clk);
    end
    start10 = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_u10", {busy10, done10, vec10, x10, y10, z10, tbl10}, 32'd0);
    chk("rst_u1", {busy1, done1, vec1, x1, y1, z1, tbl1}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", {busy10, done10, busy1, done1}, 4'd0);

    trace10(-1, -1, 24'hFAC688);
    mode = 1'b1;
    trace10(-1, -1, 24'hDD1698);
    mode = 1'b0;

    trace10(30, 80, 24'hFAC688);
    chk("no_restart", {busy10, done10}, 2'b00);

    repeat (2) @(negedge clk);
    trace10(80, 81, 24'hFAC688);
    chk("held_start_accepted", {busy10, tbl10}, {1'b1, 24'd0});
    repeat (42) @(negedge clk);
    chk("mid_vec4", {vec10, tbl10}, {3'd4, 24'h000688});
    #2 rst = 1'b1;
    #1 chk("async_rst_mid", {busy10, done10, vec10, x10, y10, z10, tbl10}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("post_rst_%0d", k), {busy10, done10, tbl10}, 32'd0);
      @(negedge clk);
    end
    trace10(-1, -1, 24'hFAC688);

    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      chk($sformatf("h1_k%0d", k), {24'd0, busy1, done1, vec1, x1, y1, z1},
          {24'd0, k < 8, k == 8, (k < 8) ? 3'(k) : 3'd0, (k < 8) ? 3'(k) : 3'd0});
      if (k == 8) chk("h1_tbl", {8'd0, tbl1}, 32'h00FAC688);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
